imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state enum and framing constants are used by the top FSM and the byte packer.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_DATA,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam int LP_HDR_BYTES      = 2;
   localparam int LP_BYTES_PER_WORD = 4;
   localparam int LP_WORD_WIDTH     = 8 * LP_BYTES_PER_WORD;
   localparam int LP_BIDX_WIDTH     = $clog2(LP_BYTES_PER_WORD);

   function automatic logic is_busy(input state_e s);
      return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: the first byte of each word lands in bits [7:0].
// ocomplete fires combinationally on the transfer that supplies the last byte of a word.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic                     iclk,
   input  logic                     irst_n,
   input  logic                     iclear,
   input  logic                     ien,
   input  logic [7:0]               ibyte,
   output logic [LP_WORD_WIDTH-1:0] oword,
   output logic                     ocomplete
);

   logic [LP_BIDX_WIDTH-1:0] idx_q, idx_d;
   logic [LP_WORD_WIDTH-1:0] word_q, word_d;
   logic [LP_WORD_WIDTH-1:0] assembled;

   // assembled already contains the incoming byte so the completed word is usable in the same cycle
   always_comb begin
      assembled = word_q;
      assembled[{idx_q, 3'b000} +: 8] = ibyte;
      idx_d  = idx_q;
      word_d = word_q;
      if (iclear) begin
         idx_d  = '0;
         word_d = '0;
      end else if (ien) begin
         idx_d  = idx_q + 1'b1;
         word_d = assembled;
      end
   end

   assign oword     = assembled;
   assign ocomplete = ien && !iclear && (idx_q == LP_BIDX_WIDTH'(LP_BYTES_PER_WORD - 1));

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding the core in reset.
// Header is a 16-bit little-endian word count; each word is written one cycle after its last byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MP_DATA_WIDTH = 32,
   parameter int MP_ADDR_WIDTH = 8
) (
   input  logic                     iclk,
   input  logic                     irst_n,
   input  logic                     istart,
   input  logic                     iabort,
   input  logic [7:0]               ibyte,
   input  logic                     ibyte_valid,
   output logic                     obyte_ready,
   output logic                     owe,
   output logic [MP_DATA_WIDTH-1:0] owaddr,
   output logic [MP_DATA_WIDTH-1:0] owdata,
   output logic                     obusy,
   output logic                     ocore_hold,
   output logic                     odone,
   output logic                     oerr
);

   localparam logic [16:0] LP_MAX_WORDS = 17'(2 ** MP_ADDR_WIDTH);

   state_e                   state_q, state_d;
   logic [7:0]               n_lo_q, n_lo_d;
   logic [15:0]              n_q, n_d;
   logic [15:0]              word_idx_q, word_idx_d;
   logic                     last_pend_q, last_pend_d;
   logic                     owe_q, owe_d;
   logic [MP_DATA_WIDTH-1:0] owaddr_q, owaddr_d;
   logic [MP_DATA_WIDTH-1:0] owdata_q, owdata_d;
   logic                     obusy_q, obusy_d;
   logic                     odone_q, odone_d;
   logic                     oerr_q, oerr_d;
   logic                     ready_q, ready_d;

   logic                     xfer;
   logic                     abort_now;
   logic                     start_ok;
   logic [15:0]              n_full;
   logic                     pk_clear;
   logic                     pk_en;
   logic [LP_WORD_WIDTH-1:0] pk_word;
   logic                     pk_complete;

   assign xfer      = ibyte_valid && ready_q;
   assign abort_now = iabort && is_busy(state_q);
   assign start_ok  = istart && !iabort &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
   assign n_full    = {ibyte, n_lo_q};
   assign pk_clear  = start_ok || abort_now;
   assign pk_en     = xfer && (state_q == ST_DATA) && !abort_now;

   byte_packer u_packer (
      .iclk      (iclk),
      .irst_n    (irst_n),
      .iclear    (pk_clear),
      .ien       (pk_en),
      .ibyte     (ibyte),
      .oword     (pk_word),
      .ocomplete (pk_complete)
   );

   // The last word's write cycle stays in DATA with last_pend set, so obusy covers it but no byte is accepted
   always_comb begin
      state_d     = state_q;
      n_lo_d      = n_lo_q;
      n_d         = n_q;
      word_idx_d  = word_idx_q;
      last_pend_d = last_pend_q;
      owe_d       = 1'b0;
      owaddr_d    = owaddr_q;
      owdata_d    = owdata_q;
      odone_d     = odone_q;
      oerr_d      = oerr_q;

      if (abort_now) begin
         state_d     = ST_IDLE;
         last_pend_d = 1'b0;
         odone_d     = 1'b0;
         oerr_d      = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start_ok) begin
                  state_d     = ST_HDR0;
                  n_lo_d      = '0;
                  n_d         = '0;
                  word_idx_d  = '0;
                  last_pend_d = 1'b0;
                  odone_d     = 1'b0;
                  oerr_d      = 1'b0;
               end
            end
            ST_HDR0: begin
               if (xfer) begin
                  n_lo_d  = ibyte;
                  state_d = ST_HDR1;
               end
            end
            ST_HDR1: begin
               if (xfer) begin
                  n_d = n_full;
                  if ((n_full == 16'd0) || ({1'b0, n_full} > LP_MAX_WORDS)) begin
                     state_d = ST_ERR;
                     oerr_d  = 1'b1;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (last_pend_q) begin
                  last_pend_d = 1'b0;
                  state_d     = ST_DONE;
                  odone_d     = 1'b1;
               end else if (pk_complete) begin
                  owe_d      = 1'b1;
                  owaddr_d   = MP_DATA_WIDTH'({word_idx_q[MP_ADDR_WIDTH-1:0], 2'b00});
                  owdata_d   = MP_DATA_WIDTH'(pk_word);
                  word_idx_d = word_idx_q + 16'd1;
                  if (word_idx_q == n_q - 16'd1) begin
                     last_pend_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      obusy_d = is_busy(state_d);
      ready_d = obusy_d && !last_pend_d;
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q     <= ST_IDLE;
         n_lo_q      <= '0;
         n_q         <= '0;
         word_idx_q  <= '0;
         last_pend_q <= 1'b0;
         owe_q       <= 1'b0;
         owaddr_q    <= '0;
         owdata_q    <= '0;
         obusy_q     <= 1'b0;
         odone_q     <= 1'b0;
         oerr_q      <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_lo_q      <= n_lo_d;
         n_q         <= n_d;
         word_idx_q  <= word_idx_d;
         last_pend_q <= last_pend_d;
         owe_q       <= owe_d;
         owaddr_q    <= owaddr_d;
         owdata_q    <= owdata_d;
         obusy_q     <= obusy_d;
         odone_q     <= odone_d;
         oerr_q      <= oerr_d;
         ready_q     <= ready_d;
      end
   end

   assign obyte_ready = ready_q;
   assign owe         = owe_q;
   assign owaddr      = owaddr_q;
   assign owdata      = owdata_q;
   assign obusy       = obusy_q;
   assign ocore_hold  = obusy_q;
   assign odone       = odone_q;
   assign oerr        = oerr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-count based session model is compared against
// the DUT every cycle, plus literal checks of the documented example streams.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        istart;
   logic        iabort;
   logic [7:0]  ibyte;
   logic        ibyte_valid;
   logic        obyte_ready;
   logic        owe;
   logic [31:0] owaddr;
   logic [31:0] owdata;
   logic        obusy;
   logic        ocore_hold;
   logic        odone;
   logic        oerr;

   int vecCount  = 0;
   int missCount = 0;

   logic [31:0] logAddr[$];
   logic [31:0] logData[$];

   // Session model: tracks how many bytes the session has consumed and derives every output from that count
   bit          mActive, mFinal, mDone, mErr, mWe, mXfer;
   int          mCnt, mN, mK;
   logic [7:0]  mNlo;
   logic [31:0] mWord, mAddr, mData;

   always #5 clk = ~clk;

   imem_loader dut (
      .iclk        (clk),
      .irst_n      (rst_n),
      .istart      (istart),
      .iabort      (iabort),
      .ibyte       (ibyte),
      .ibyte_valid (ibyte_valid),
      .obyte_ready (obyte_ready),
      .owe         (owe),
      .owaddr      (owaddr),
      .owdata      (owdata),
      .obusy       (obusy),
      .ocore_hold  (ocore_hold),
      .odone       (odone),
      .oerr        (oerr)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mActive = 0; mFinal = 0; mDone = 0; mErr = 0; mWe = 0;
         mCnt = 0; mN = 0; mNlo = '0; mWord = '0; mAddr = '0; mData = '0;
      end else begin
         mXfer = ibyte_valid && mActive && !mFinal;
         mWe   = 0;
         if (mActive && iabort) begin
            mActive = 0; mFinal = 0; mDone = 0; mErr = 0;
         end else if (!mActive && istart && !iabort) begin
            mActive = 1; mCnt = 0; mN = 0; mDone = 0; mErr = 0;
         end else if (mFinal) begin
            mFinal = 0; mActive = 0; mDone = 1;
         end else if (mXfer) begin
            if (mCnt == 0) begin
               mNlo = ibyte;
            end else if (mCnt == 1) begin
               mN = int'(ibyte) * 256 + int'(mNlo);
               if (mN == 0 || mN > 256) begin
                  mActive = 0; mErr = 1;
               end
            end else begin
               mK = mCnt - 2;
               mWord[8*(mK%4) +: 8] = ibyte;
               if (mK % 4 == 3) begin
                  mWe   = 1;
                  mAddr = 32'((mK / 4) * 4);
                  mData = mWord;
                  if (mK / 4 == mN - 1) mFinal = 1;
               end
            end
            mCnt++;
         end
      end
   end

   always begin
      @(posedge clk);
      #2;
      checkOutput("owe", {31'b0, owe}, {31'b0, mWe});
      checkOutput("obusy", {31'b0, obusy}, {31'b0, mActive});
      checkOutput("ocore_hold", {31'b0, ocore_hold}, {31'b0, mActive});
      checkOutput("odone", {31'b0, odone}, {31'b0, mDone});
      checkOutput("oerr", {31'b0, oerr}, {31'b0, mErr});
      checkOutput("obyte_ready", {31'b0, obyte_ready}, {31'b0, mActive && !mFinal});
      if (mWe) begin
         checkOutput("owaddr", owaddr, mAddr);
         checkOutput("owdata", owdata, mData);
      end
      if (!rst_n) begin
         checkOutput("owaddr_rst", owaddr, 32'h0);
         checkOutput("owdata_rst", owdata, 32'h0);
      end
      if (owe) begin
         logAddr.push_back(owaddr);
         logData.push_back(owdata);
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_owe"}, {31'b0, owe}, 32'h0);
      checkOutput({tag, "_owaddr"}, owaddr, 32'h0);
      checkOutput({tag, "_owdata"}, owdata, 32'h0);
      checkOutput({tag, "_obusy"}, {31'b0, obusy}, 32'h0);
      checkOutput({tag, "_hold"}, {31'b0, ocore_hold}, 32'h0);
      checkOutput({tag, "_odone"}, {31'b0, odone}, 32'h0);
      checkOutput({tag, "_oerr"}, {31'b0, oerr}, 32'h0);
      checkOutput({tag, "_ready"}, {31'b0, obyte_ready}, 32'h0);
   endtask

   task automatic sendByte(input logic [7:0] b, input int maxGap);
      int gap;
      bit rdy;
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      repeat (gap) begin
         ibyte = 8'($urandom);
         @(negedge clk);
      end
      ibyte       = b;
      ibyte_valid = 1'b1;
      for (int t = 0; t < 40; t++) begin
         rdy = obyte_ready;
         @(negedge clk);
         if (rdy) begin
            ibyte_valid = 1'b0;
            return;
         end
      end
      ibyte_valid = 1'b0;
      checkOutput("byte_accept_timeout", 32'h0, 32'h1);
   endtask

   task automatic applyStimulus(input logic [7:0] bs[$], input int maxGap, input int midStart);
      istart = 1'b1;
      @(negedge clk);
      istart = 1'b0;
      foreach (bs[i]) begin
         if (i == midStart) begin
            istart = 1'b1;
            @(negedge clk);
            istart = 1'b0;
         end
         sendByte(bs[i], maxGap);
      end
   endtask

   task automatic waitEnd();
      for (int t = 0; t < 30; t++) begin
         if (odone || oerr) return;
         @(negedge clk);
      end
      checkOutput("session_end_timeout", 32'h0, 32'h1);
   endtask

   function automatic void makeStream(input int n, output logic [7:0] bs[$], output logic [31:0] ws[$]);
      logic [31:0] w;
      bs.delete();
      ws.delete();
      bs.push_back(8'(n));
      bs.push_back(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         ws.push_back(w);
         for (int b = 0; b < 4; b++) bs.push_back(w[8*b +: 8]);
      end
   endfunction

   task automatic checkLog(input logic [31:0] ws[$], input string tag);
      checkOutput({tag, "_count"}, 32'(logData.size()), 32'(ws.size()));
      foreach (ws[i]) begin
         if (i < logData.size()) begin
            checkOutput({tag, "_addr"}, logAddr[i], 32'(i * 4));
            checkOutput({tag, "_data"}, logData[i], ws[i]);
         end
      end
   endtask

   task automatic clearLog();
      logAddr.delete();
      logData.delete();
   endtask

   initial begin
      logic [7:0]  bs[$];
      logic [31:0] ws[$];
      int          n;
      int          cut;

      rst_n = 1'b0; istart = 1'b0; iabort = 1'b0; ibyte = 8'h00; ibyte_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] example stream of two words");
      clearLog();
      bs = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      applyStimulus(bs, 0, -1);
      waitEnd();
      checkOutput("ex_count", 32'(logData.size()), 32'd2);
      if (logData.size() == 2) begin
         checkOutput("ex_addr0", logAddr[0], 32'h0);
         checkOutput("ex_data0", logData[0], 32'h0000_0013);
         checkOutput("ex_addr1", logAddr[1], 32'h4);
         checkOutput("ex_data1", logData[1], 32'h0010_0093);
      end
      checkOutput("ex_odone", {31'b0, odone}, 32'h1);
      checkOutput("ex_obusy", {31'b0, obusy}, 32'h0);

      $display("[TB] zero-length header");
      clearLog();
      bs = '{8'h00, 8'h00};
      applyStimulus(bs, 0, -1);
      ibyte = 8'hA5; ibyte_valid = 1'b1;
      repeat (3) @(negedge clk);
      ibyte_valid = 1'b0;
      checkOutput("zero_oerr", {31'b0, oerr}, 32'h1);
      checkOutput("zero_ready", {31'b0, obyte_ready}, 32'h0);
      checkOutput("zero_writes", 32'(logData.size()), 32'd0);

      $display("[TB] oversize and full-size headers");
      bs = '{8'h01, 8'h01};
      applyStimulus(bs, 0, -1);
      @(negedge clk);
      checkOutput("n257_oerr", {31'b0, oerr}, 32'h1);
      clearLog();
      makeStream(256, bs, ws);
      applyStimulus(bs, 0, -1);
      waitEnd();
      checkLog(ws, "n256");
      if (logAddr.size() > 0) checkOutput("n256_last_addr", logAddr[logAddr.size()-1], 32'h3FC);
      checkOutput("n256_odone", {31'b0, odone}, 32'h1);

      $display("[TB] gap-free run then gapped run with a stray start");
      makeStream(6, bs, ws);
      clearLog();
      applyStimulus(bs, 0, -1);
      waitEnd();
      checkLog(ws, "nogap");
      clearLog();
      applyStimulus(bs, 3, 7);
      waitEnd();
      checkLog(ws, "gap");
      checkOutput("gap_odone", {31'b0, odone}, 32'h1);

      $display("[TB] abort alongside the last byte of a word");
      clearLog();
      bs = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
      applyStimulus(bs, 0, -1);
      ibyte = 8'h44; ibyte_valid = 1'b1; iabort = 1'b1;
      @(negedge clk);
      ibyte_valid = 1'b0; iabort = 1'b0;
      checkOutput("abort_obusy", {31'b0, obusy}, 32'h0);
      checkOutput("abort_odone", {31'b0, odone}, 32'h0);
      checkOutput("abort_oerr", {31'b0, oerr}, 32'h0);
      repeat (2) @(negedge clk);
      checkOutput("abort_writes", 32'(logData.size()), 32'd0);

      $display("[TB] abort with start during header");
      istart = 1'b1; @(negedge clk); istart = 1'b0;
      sendByte(8'h03, 0);
      istart = 1'b1; iabort = 1'b1;
      @(negedge clk);
      istart = 1'b0; iabort = 1'b0;
      checkOutput("abortstart_obusy", {31'b0, obusy}, 32'h0);

      $display("[TB] reset in the middle of a word");
      clearLog();
      bs = '{8'h01, 8'h00, 8'hAA, 8'hBB};
      applyStimulus(bs, 0, -1);
      rst_n = 1'b0;
      #1;
      checkAllZero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("midrst_writes", 32'(logData.size()), 32'd0);
      bs = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      applyStimulus(bs, 0, -1);
      waitEnd();
      checkOutput("postrst_count", 32'(logData.size()), 32'd1);
      if (logData.size() == 1) begin
         checkOutput("postrst_addr", logAddr[0], 32'h0);
         checkOutput("postrst_data", logData[0], 32'h1234_5678);
      end

      $display("[TB] randomized sessions");
      for (int it = 0; it < 20; it++) begin
         n = int'($urandom_range(5, 1));
         makeStream(n, bs, ws);
         clearLog();
         if ($urandom_range(3, 0) == 0) begin
            cut = int'($urandom_range(bs.size() - 1, 1));
            bs = bs[0:cut-1];
            applyStimulus(bs, 2, -1);
            iabort = 1'b1;
            @(negedge clk);
            iabort = 1'b0;
            @(negedge clk);
         end else begin
            applyStimulus(bs, 2, -1);
            waitEnd();
            checkLog(ws, "rand");
         end
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
